// File: rtl/spi_audio_tx_fifo.sv
// rtl/spi_audio_tx_fifo.sv - FIFO-buffered multi-channel PCM SPI slave transmitter
//
// Buffers PCM frames from the audio pipeline and serialises them MSB-first on
// MISO, channel 0 first. SCLK and CS are oversampled in the clk domain.
//
// Ports:
//   clk           system clock, at least 8x SCLK
//   reset_n       asynchronous active-low reset
//   sample_in     frame, channel k in bits [(k+1)*DATA_W-1 : k*DATA_W]
//   sample_valid  one-cycle push strobe
//   spi_sclk      SPI clock from master (asynchronous)
//   spi_cs_n      chip select from master, active low (asynchronous)
//   spi_miso      registered serial data to master
//   fifo_level    frames currently buffered
//   overflow      pulse: push dropped, FIFO full
//   underrun      pulse: frame load found FIFO empty
module spi_audio_tx_fifo #(
  parameter int DATA_W       = 16,
  parameter int NUM_CH       = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int CPOL         = 0,
  parameter int CPHA         = 0,
  parameter int UNDERRUN_RPT = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_CH*DATA_W-1:0]         sample_in,
  input  logic                             sample_valid,
  input  logic                             spi_sclk,
  input  logic                             spi_cs_n,
  output logic                             spi_miso,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             overflow,
  output logic                             underrun
);

  localparam int FRAME_W = NUM_CH * DATA_W;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = $clog2(FIFO_DEPTH + 1);
  localparam int CW      = $clog2(FRAME_W + 1);
  localparam bit IDLE    = (CPOL != 0);
  localparam bit PHA1    = (CPHA != 0);
  localparam bit RPT     = (UNDERRUN_RPT != 0);

  logic [2:0]         sclk_sync;
  logic [2:0]         cs_sync;
  logic [FRAME_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [FRAME_W-1:0] frame_in;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] last_frame;
  logic [CW-1:0]      bit_cnt;
  logic               load_d;

  logic lead, trail, cs_low, cs_fall, cnt_edge, frame_done, load, do_pop, do_push;

  // Edges are taken between stage 2 and stage 3 of each synchroniser.
  assign lead       = (sclk_sync[1] != sclk_sync[2]) && (sclk_sync[1] != IDLE);
  assign trail      = (sclk_sync[1] != sclk_sync[2]) && (sclk_sync[1] == IDLE);
  assign cs_low     = ~cs_sync[1];
  assign cs_fall    = ~cs_sync[1] & cs_sync[2];
  assign cnt_edge   = PHA1 ? trail : lead;
  assign frame_done = cs_low && cnt_edge && (bit_cnt == CW'(FRAME_W - 1));
  assign load       = cs_fall || frame_done;
  // No bypass: a pop needs a frame already stored before this cycle.
  assign do_pop     = load && (fifo_level != '0);
  assign do_push    = sample_valid && (fifo_level != LW'(FIFO_DEPTH));

  // Reorder channels so channel 0 sits in the MSBs and leaves first.
  always_comb begin
    frame_in = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      frame_in[FRAME_W-1-k*DATA_W -: DATA_W] = sample_in[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= {3{IDLE}};
      cs_sync   <= 3'b111;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_sclk};
      cs_sync   <= {cs_sync[1:0], spi_cs_n};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= frame_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= sample_valid && !do_push;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      last_frame <= '0;
      bit_cnt    <= '0;
      spi_miso   <= 1'b0;
      underrun   <= 1'b0;
      load_d     <= 1'b0;
    end else begin
      underrun <= load && (fifo_level == '0);
      load_d   <= 1'b0;
      if (!cs_low) begin
        // Deselected: abort any frame in flight; popped data is simply dropped.
        bit_cnt  <= '0;
        spi_miso <= 1'b0;
      end else begin
        if (cnt_edge) bit_cnt <= frame_done ? '0 : bit_cnt + 1'b1;
        if (load) begin
          load_d <= 1'b1;
          if (do_pop) begin
            shreg      <= mem[rd_ptr];
            last_frame <= mem[rd_ptr];
          end else begin
            shreg <= RPT ? last_frame : '0;
          end
        end else if (!PHA1 && load_d) begin
          spi_miso <= shreg[FRAME_W-1];
        end else if (!PHA1 && trail && (bit_cnt != '0)) begin
          // bit_cnt==0 here means the trailing edge after a completed frame,
          // whose reload already presented the new MSB; do not shift it out.
          shreg    <= {shreg[FRAME_W-2:0], 1'b0};
          spi_miso <= shreg[FRAME_W-2];
        end else if (PHA1 && lead) begin
          shreg    <= {shreg[FRAME_W-2:0], 1'b0};
          spi_miso <= shreg[FRAME_W-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_audio_tx_fifo.sv
// tb/tb_spi_audio_tx_fifo.sv - directed self-checking bench for spi_audio_tx_fifo
module tb_spi_audio_tx_fifo;

  localparam int HALF = 4;  // SCLK half period in clk cycles (SCLK = clk/8)

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] sample_in;
  logic        sample_valid;
  logic        sck;
  logic        cs_a;  // CS for CPHA=0 devices
  logic        cs_b;  // CS for CPHA=1 devices

  logic       miso00, miso01, miso10, miso11, misor;
  logic [3:0] lvl00, lvl01, lvl10, lvl11, lvlr;
  logic       ov00, ov01, ov10, ov11, ovr;
  logic       ur00, ur01, ur10, ur11, urr;

  logic [255:0] rx00, rx01, rx10, rx11, rxr;

  int n_vec  = 0;
  int n_err  = 0;
  int un_cnt = 0;
  int ov_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ur00) un_cnt++;
    if (ov00) ov_cnt++;
  end

  spi_audio_tx_fifo #(.CPOL(0), .CPHA(0), .UNDERRUN_RPT(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .spi_sclk(sck), .spi_cs_n(cs_a), .spi_miso(miso00), .fifo_level(lvl00),
    .overflow(ov00), .underrun(ur00));

  spi_audio_tx_fifo #(.CPOL(0), .CPHA(1), .UNDERRUN_RPT(0)) u_m01 (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .spi_sclk(sck), .spi_cs_n(cs_b), .spi_miso(miso01), .fifo_level(lvl01),
    .overflow(ov01), .underrun(ur01));

  spi_audio_tx_fifo #(.CPOL(1), .CPHA(0), .UNDERRUN_RPT(0)) u_m10 (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .spi_sclk(~sck), .spi_cs_n(cs_a), .spi_miso(miso10), .fifo_level(lvl10),
    .overflow(ov10), .underrun(ur10));

  spi_audio_tx_fifo #(.CPOL(1), .CPHA(1), .UNDERRUN_RPT(0)) u_m11 (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .spi_sclk(~sck), .spi_cs_n(cs_b), .spi_miso(miso11), .fifo_level(lvl11),
    .overflow(ov11), .underrun(ur11));

  spi_audio_tx_fifo #(.CPOL(0), .CPHA(0), .UNDERRUN_RPT(1)) u_rpt (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .spi_sclk(sck), .spi_cs_n(cs_a), .spi_miso(misor), .fifo_level(lvlr),
    .overflow(ovr), .underrun(urr));

  task automatic push(input logic [15:0] ch0, input logic [15:0] ch1);
    @(negedge clk);
    sample_in    = {ch1, ch0};
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
  endtask

  // Master: leading edge = sck rising. CPHA=0 devices are sampled on the
  // leading edge, CPHA=1 devices on the trailing edge. With end_on_sample the
  // master releases CS together with the final sampling edge.
  task automatic spi_xfer(input int nbits, input bit end_on_sample);
    rx00 = '0; rx01 = '0; rx10 = '0; rx11 = '0; rxr = '0;
    @(negedge clk);
    cs_a = 1'b0;
    cs_b = 1'b0;
    repeat (2*HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sck  = 1'b1;
      rx00 = {rx00[254:0], miso00};
      rx10 = {rx10[254:0], miso10};
      rxr  = {rxr[254:0], misor};
      if (end_on_sample && i == nbits - 1) cs_a = 1'b1;
      repeat (HALF) @(negedge clk);
      sck  = 1'b0;
      rx01 = {rx01[254:0], miso01};
      rx11 = {rx11[254:0], miso11};
      if (end_on_sample && i == nbits - 1) cs_b = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    cs_a = 1'b1;
    cs_b = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({miso00, miso01, miso10, miso11, misor} !== 5'b0) begin
      n_err++; $display("FAIL reset_miso got %b want 00000", {miso00, miso01, miso10, miso11, misor});
    end
    n_vec++;
    if ({lvl00, lvl01, lvl10, lvl11, lvlr} !== 20'h0) begin
      n_err++; $display("FAIL reset_level got %h want 00000", {lvl00, lvl01, lvl10, lvl11, lvlr});
    end
    n_vec++;
    if ({ov00, ov01, ov10, ov11, ovr, ur00, ur01, ur10, ur11, urr} !== 10'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 0", {ov00, ov01, ov10, ov11, ovr, ur00, ur01, ur10, ur11, urr});
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++;
    if (miso00 !== 1'b0 || lvl00 !== 4'd0) begin
      n_err++; $display("FAIL post_reset got miso=%b lvl=%0d want 0/0", miso00, lvl00);
    end
  endtask

  task automatic test_single_frame;
    int u0;
    u0 = un_cnt;
    push(16'hA5C3, 16'h1234);
    n_vec++;
    if (lvl00 !== 4'd1) begin n_err++; $display("FAIL single_level_before got %0d want 1", lvl00); end
    spi_xfer(32, 1'b1);
    n_vec++;
    if (rx00[31:0] !== 32'hA5C31234) begin n_err++; $display("FAIL single_data got %h want a5c31234", rx00[31:0]); end
    n_vec++;
    if (lvl00 !== 4'd0) begin n_err++; $display("FAIL single_level_after got %0d want 0", lvl00); end
    n_vec++;
    if (un_cnt != u0) begin n_err++; $display("FAIL single_underrun got %0d pulses want 0", un_cnt - u0); end
  endtask

  task automatic test_back_to_back;
    logic [95:0] exp;
    int u0;
    u0  = un_cnt;
    exp = 96'h0F0F8001_7FFEC3A5_0001FFFF;
    push(16'h0F0F, 16'h8001);
    push(16'h7FFE, 16'hC3A5);
    push(16'h0001, 16'hFFFF);
    n_vec++;
    if (lvl00 !== 4'd3) begin n_err++; $display("FAIL stream_level_before got %0d want 3", lvl00); end
    spi_xfer(96, 1'b1);
    n_vec++;
    if (rx00[95:0] !== exp) begin n_err++; $display("FAIL stream_mode00 got %h want %h", rx00[95:0], exp); end
    n_vec++;
    if (rx01[95:0] !== exp) begin n_err++; $display("FAIL stream_mode01 got %h want %h", rx01[95:0], exp); end
    n_vec++;
    if (rx10[95:0] !== exp) begin n_err++; $display("FAIL stream_mode10 got %h want %h", rx10[95:0], exp); end
    n_vec++;
    if (rx11[95:0] !== exp) begin n_err++; $display("FAIL stream_mode11 got %h want %h", rx11[95:0], exp); end
    n_vec++;
    if (lvl00 !== 4'd0) begin n_err++; $display("FAIL stream_level_after got %0d want 0", lvl00); end
    n_vec++;
    if (un_cnt != u0) begin n_err++; $display("FAIL stream_underrun got %0d pulses want 0", un_cnt - u0); end
  endtask

  task automatic test_underrun;
    int u0;
    push(16'hDEAD, 16'hBEEF);
    spi_xfer(32, 1'b1);
    n_vec++;
    if (rxr[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL rpt_first got %h want deadbeef", rxr[31:0]); end
    u0 = un_cnt;
    spi_xfer(32, 1'b1);
    n_vec++;
    if (un_cnt - u0 != 1) begin n_err++; $display("FAIL underrun_pulses got %0d want 1", un_cnt - u0); end
    n_vec++;
    if (rx00[31:0] !== 32'h0) begin n_err++; $display("FAIL underrun_zero00 got %h want 0", rx00[31:0]); end
    n_vec++;
    if (rx11[31:0] !== 32'h0) begin n_err++; $display("FAIL underrun_zero11 got %h want 0", rx11[31:0]); end
    n_vec++;
    if (rxr[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL underrun_repeat got %h want deadbeef", rxr[31:0]); end
  endtask

  task automatic test_overflow;
    logic [255:0] exp;
    int o0;
    o0  = ov_cnt;
    exp = '0;
    for (int k = 1; k <= 8; k++) begin
      push(16'(16'h1000 + k), 16'(16'h2000 + k));
      exp = {exp[223:0], 16'(16'h1000 + k), 16'(16'h2000 + k)};
    end
    n_vec++;
    if (ov_cnt != o0 || lvl00 !== 4'd8) begin
      n_err++; $display("FAIL ovf_before got ov=%0d lvl=%0d want 0/8", ov_cnt - o0, lvl00);
    end
    push(16'h1009, 16'h2009);
    n_vec++;
    if (ov_cnt - o0 != 1) begin n_err++; $display("FAIL ovf_pulse got %0d want 1", ov_cnt - o0); end
    n_vec++;
    if (lvl00 !== 4'd8) begin n_err++; $display("FAIL ovf_level got %0d want 8", lvl00); end
    spi_xfer(256, 1'b1);
    n_vec++;
    if (rx00 !== exp) begin n_err++; $display("FAIL ovf_data got %h want %h", rx00, exp); end
    n_vec++;
    if (lvl00 !== 4'd0) begin n_err++; $display("FAIL ovf_drain got %0d want 0", lvl00); end
  endtask

  task automatic test_abort;
    push(16'hCAFE, 16'h0123);
    push(16'h4567, 16'h89AB);
    spi_xfer(10, 1'b0);
    n_vec++;
    if (rx00[9:0] !== 10'h32B) begin n_err++; $display("FAIL abort_partial got %h want 32b", rx00[9:0]); end
    n_vec++;
    if (lvl00 !== 4'd1) begin n_err++; $display("FAIL abort_level got %0d want 1", lvl00); end
    spi_xfer(32, 1'b1);
    n_vec++;
    if (rx00[31:0] !== 32'h456789AB) begin n_err++; $display("FAIL abort_next00 got %h want 456789ab", rx00[31:0]); end
    n_vec++;
    if (rx01[31:0] !== 32'h456789AB) begin n_err++; $display("FAIL abort_next01 got %h want 456789ab", rx01[31:0]); end
  endtask

  task automatic test_reset_mid_frame;
    push(16'hFFFF, 16'hFFFF);
    push(16'h1111, 16'h2222);
    @(negedge clk);
    cs_a = 1'b0;
    cs_b = 1'b0;
    repeat (2*HALF) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    n_vec++;
    if (miso00 !== 1'b1 || lvl00 !== 4'd1) begin
      n_err++; $display("FAIL midframe_pre got miso=%b lvl=%0d want 1/1", miso00, lvl00);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({miso00, miso01, miso10, miso11, misor} !== 5'b0) begin
      n_err++; $display("FAIL midframe_miso got %b want 00000", {miso00, miso01, miso10, miso11, misor});
    end
    n_vec++;
    if (lvl00 !== 4'd0 || lvl11 !== 4'd0) begin
      n_err++; $display("FAIL midframe_level got %0d/%0d want 0/0", lvl00, lvl11);
    end
    cs_a = 1'b1;
    cs_b = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset_n      = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    sck          = 1'b0;
    cs_a         = 1'b1;
    cs_b         = 1'b1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_overflow();
    test_abort();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_audio_tx_fifo.md
Name: spi_audio_tx_fifo

Overview:
Parametrised successor to the single-sample SPI audio slave transmitter. It buffers multi-channel PCM frames from the FIR/audio pipeline in a FIFO and serialises them MSB-first to the MCU (SPI master) on MISO. SPI clock and chip select are oversampled in the system clock domain, and SPI mode (CPOL/CPHA) is configurable. Continuous streaming under a held chip select, plus underrun and overflow reporting, are behaviours the previous block did not have.

Parameters:
DATA_W, 16, bits per channel sample (8..32)
NUM_CH, 2, channels per frame; channel 0 is transmitted first
FIFO_DEPTH, 8, frames buffered; power of 2, >=2
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge / change on trailing edge; 1 = change on leading edge / sample on trailing edge
UNDERRUN_RPT, 0, 0 = send zeros on underrun; 1 = resend last transmitted frame

Ports:
clk  in  1  system clock; must be >= 8x the SPI SCLK frequency
reset_n  in  1  asynchronous active-low reset
sample_in  in  NUM_CH*DATA_W  frame; channel k occupies bits [(k+1)*DATA_W-1 : k*DATA_W]; signed PCM
sample_valid  in  1  one-cycle strobe; push sample_in
spi_sclk  in  1  SPI clock from MCU (asynchronous)
spi_cs_n  in  1  chip select from MCU, active low (asynchronous)
spi_miso  out  1  serial data to MCU
fifo_level  out  $clog2(FIFO_DEPTH+1)  number of frames currently buffered
overflow  out  1  one-cycle pulse: push dropped because FIFO was full
underrun  out  1  one-cycle pulse: frame load found FIFO empty

Behaviour:
- Reset: FIFO empty, fifo_level=0, spi_miso=0, overflow=0, underrun=0, shift register=0, last-frame register=0, bit counter=0.
- Sync: spi_sclk and spi_cs_n pass through 2-FF synchronisers, then a third register for edge detection. The SPI-side reaction latency is 3 clk cycles from a pin edge.
- Leading edge = synced SCLK leaving CPOL. Trailing edge = synced SCLK returning to CPOL.
- FIFO push:
  - On sample_valid with FIFO not full: write frame, level+1.
  - On sample_valid with FIFO full: drop the frame, pulse overflow; contents unchanged.
- Frame load occurs on a synced CS falling edge, and on completion of bit FRAME_W (= NUM_CH*DATA_W) while CS is still low (streaming).
  - FIFO non-empty: pop head into the shift register and copy it to the last-frame register.
  - FIFO empty: load zeros (UNDERRUN_RPT=0) or the last-frame register (UNDERRUN_RPT=1), and pulse underrun.
- A push and a pop in the same cycle are both performed; level is unchanged. A push while FIFO is full is still dropped even if a pop occurs that cycle. There is no bypass: a push into an empty FIFO in the same cycle as a load is an underrun.
- Shift, CPHA=0:
  - MISO = MSB of the shift register, registered in the cycle after the load.
  - Each trailing edge shifts left by 1 and updates MISO; the bit counter increments on each leading edge.
- Shift, CPHA=1:
  - Each leading edge drives the next bit; the first leading edge drives the MSB.
  - The counter increments on each trailing edge.
- Completion: after FRAME_W counted edges the counter wraps to 0; if CS is still low, a load occurs in the same cycle, so the stream is gapless.
- CS high (synced):
  - spi_miso=0 and bit counter=0; SCLK edges are ignored.
  - CS rising mid-frame aborts the frame; popped data is discarded and not re-queued.
- spi_miso is always driven, never tristated; it is registered.
- Asynchronous reset mid-frame returns all state to reset values immediately.

Test Plan:
- DATA_W=16, NUM_CH=2, CPOL=0, CPHA=0: push frame {ch1=16'h1234, ch0=16'hA5C3}, one CS transaction of 32 SCLKs -> master samples 0xA5C31234 MSB-first; fifo_level 1->0; underrun never pulses.
- Push 3 frames, hold CS low for 96 SCLKs -> three frames received back-to-back with no gap; fifo_level reaches 0 after the third load.
- Empty FIFO, CS falls with UNDERRUN_RPT=0 -> underrun pulses once and 32 zero bits are received. Repeat with UNDERRUN_RPT=1 after frame 0xDEADBEEF was sent -> 0xDEADBEEF is resent.
- Push 9 frames at FIFO_DEPTH=8 -> overflow pulses once on the 9th push; fifo_level=8; frames 1-8 are read back intact.
- Raise CS after 10 bits, then start a new transaction -> the next FIFO frame is sent from its MSB and the aborted frame is not resent.
- Sweep all four CPOL/CPHA combinations with an SCLK at clk/8 -> data is correct in every mode. Assert reset_n mid-frame -> spi_miso=0 and fifo_level=0 immediately.
